vga_reg_access_arbiter: RTL and testbench
=========================================

Name: vga_reg_access_arbiter

Overview:
- Two-requester AXI4-Lite master that shares the VGA slave's register file.
- Requester 0 is the text/keyboard engine; requester 1 is the colour-cycling engine.
- Grants one single-beat read or write at a time, round-robin, and drives the slave's AXI4-Lite port.
- Returns read data and response to the granted requester.

Parameters:
- ADDR_WIDTH, 4: byte address width. Four 32-bit registers at 0x0, 0x4, 0x8, 0xC.
- DATA_WIDTH, 32: register data width. Must be 32.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  bit i: requester i has a pending access; held until req_ready[i]
- req_we  in  2  bit i: 1 = write, 0 = read
- req_addr  in  2*ADDR_WIDTH  slice i = byte address of requester i
- req_wdata  in  2*DATA_WIDTH  slice i = write data of requester i
- req_ready  out  2  one-cycle pulse; request i accepted and captured
- done  out  2  one-cycle pulse; access for requester i completed
- rd_data  out  DATA_WIDTH  read data; valid while done is high
- rd_resp  out  2  AXI RESP/BRESP of the completed access; valid while done is high
- err  out  1  sticky; set when any response is not OKAY
- m_axi_awaddr, m_axi_awprot(3), m_axi_awvalid  out; m_axi_awready  in
- m_axi_wdata, m_axi_wstrb(4), m_axi_wvalid  out; m_axi_wready  in
- m_axi_bresp(2), m_axi_bvalid  in; m_axi_bready  out
- m_axi_araddr, m_axi_arprot(3), m_axi_arvalid  out; m_axi_arready  in
- m_axi_rdata, m_axi_rresp(2), m_axi_rvalid  in; m_axi_rready  out

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, last_grant = 1 (requester 0 wins the first tie).
- Constant outputs: awprot = arprot = 0; wstrb = 4'hF.
- IDLE state:
  - Grant is combinational from req_valid.
  - If only one requester is valid, that requester is granted.
  - If both are valid, grant the requester that is not last_grant.
  - On a grant: req_ready[g] pulses, addr/we/wdata of g are registered, last_grant <= g.
  - Next state is WR_ADDR_DATA if we = 1, otherwise RD_ADDR.
- WR_ADDR_DATA state:
  - awvalid and wvalid both rise on the cycle after the grant.
  - Each valid drops on the cycle after its own handshake (valid & ready). AW and W complete independently, in either order or together.
  - Exit to WR_RESP once both handshakes have occurred.
  - The wait for ready is unbounded.
- WR_RESP state: bready = 1. On bvalid: capture bresp and go to IDLE.
- RD_ADDR state: arvalid = 1. On arready: go to RD_DATA.
- RD_DATA state: rready = 1. On rvalid: capture rdata and rresp, then go to IDLE.
- Valid stability: once asserted, awvalid, wvalid and arvalid hold their address and data stable until the handshake.
- bready and rready are high only in their own states.
- Completion:
  - In the first IDLE cycle after a B or R handshake, done[g] = 1 for exactly one cycle.
  - rd_data and rd_resp hold their values until the next completion. rd_data is unchanged by writes.
  - A new grant may occur in that same cycle.
- err is set when the captured response is not 2'b00. It is cleared only by reset.
- Latency with an always-ready slave (cycle T = grant):
  - Write: AW/W at T+1, B at T+2, done at T+3.
  - Read: AR at T+1, R at T+2, done at T+3.
  - Back-to-back throughput: one access per 3 cycles.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- A request that deasserts before its grant is dropped without effect.
- Reset mid-transaction: all valids and readies drop the next cycle, FSM returns to IDLE, no done is issued, and the in-flight access is abandoned. The slave is reset by the same reset.

Test Plan:
- Req0 writes 0x00000001/2/3/4 to addresses 0x0/0x4/0x8/0xC, then reads all four -> rd_data = 1, 2, 3, 4; rd_resp = 0; err = 0; done[0] exactly 8 times.
- req_valid = 2'b11 held for 6 accesses with an always-ready slave -> req_ready order 0,1,0,1,0,1; each done at grant+3.
- Slave holds awready low 3 cycles, wready low 1 cycle -> awvalid stays high 4 cycles, wvalid high 2 cycles, awaddr stable throughout; one B accepted; single done.
- Slave returns bresp = 2'b10 on a write by req1 -> done[1] with rd_resp = 2'b10; err = 1 and stays 1 through later OKAY accesses.
- reset asserted while in RD_DATA (rvalid held low) -> next cycle arvalid = rready = 0, FSM in IDLE, no done pulse; the next req0 read returns the slave's reset value (0).

Source files
------------

// File: rtl/vga_reg_access_arbiter_if.sv
// Requester-side and AXI4-Lite bundles for the VGA register access arbiter.
// vga_req_if: 2 requesters (valid/we/addr/wdata in; ready/done/rd_data/rd_resp/err out).
// vga_axil_if: single-beat AXI4-Lite master port (AW, W, B, AR, R channels).
interface vga_req_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic [1:0]      req_valid;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_ready;
  logic [1:0]      done;
  logic [DW-1:0]   rd_data;
  logic [1:0]      rd_resp;
  logic            err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, done, rd_data, rd_resp, err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, done, rd_data, rd_resp, err
  );
endinterface

interface vga_axil_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic [AW-1:0] m_axi_awaddr;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
  logic [AW-1:0] m_axi_araddr;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid;
  logic          m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/vga_reg_access_arbiter.sv
// Round-robin two-requester AXI4-Lite master for the VGA register file.
// Ports: clock, reset (sync, active-high), req (vga_req_if.slave), axi (vga_axil_if.master).
module vga_reg_access_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  vga_req_if.slave   req,
  vga_axil_if.master axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA
  } state_t;

  state_t                r_state;
  logic                  r_last;
  logic                  r_gnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic [1:0]            r_done;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [1:0]            r_rd_resp;
  logic                  r_err;

  logic                  w_any;
  logic                  w_gnt;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [1:0]            w_ready;
  logic                  w_aw_open;
  logic                  w_w_open;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    w_any = |req.req_valid;
    if (req.req_valid == 2'b11)
      w_gnt = ~r_last;
    else
      w_gnt = req.req_valid[1];
  end

  always_comb begin
    w_we    = req.req_we[w_gnt];
    w_addr  = w_gnt ? req.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                    : req.req_addr[ADDR_WIDTH-1:0];
    w_wdata = w_gnt ? req.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                    : req.req_wdata[DATA_WIDTH-1:0];
  end

  always_comb begin
    w_ready = 2'b00;
    if (r_state == S_IDLE && w_any && !reset)
      w_ready = w_gnt ? 2'b10 : 2'b01;
  end

  // A channel stays open until its own handshake; AW and W finish independently.
  assign w_aw_open = r_awvalid & ~axi.m_axi_awready;
  assign w_w_open  = r_wvalid  & ~axi.m_axi_wready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_gnt     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_done    <= 2'b00;
      r_rd_data <= '0;
      r_rd_resp <= 2'b00;
      r_err     <= 1'b0;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_gnt;
            r_last  <= w_gnt;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            if (w_we) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_WR: begin
          r_awvalid <= w_aw_open;
          r_wvalid  <= w_w_open;
          if (!w_aw_open && !w_w_open) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (axi.m_axi_bvalid) begin
            r_bready  <= 1'b0;
            r_rd_resp <= axi.m_axi_bresp;
            r_err     <= r_err | (|axi.m_axi_bresp);
            r_done    <= r_gnt ? 2'b10 : 2'b01;
            r_state   <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (axi.m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (axi.m_axi_rvalid) begin
            r_rready  <= 1'b0;
            r_rd_data <= axi.m_axi_rdata;
            r_rd_resp <= axi.m_axi_rresp;
            r_err     <= r_err | (|axi.m_axi_rresp);
            r_done    <= r_gnt ? 2'b10 : 2'b01;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req.req_ready = w_ready;
  assign req.done      = r_done;
  assign req.rd_data   = r_rd_data;
  assign req.rd_resp   = r_rd_resp;
  assign req.err       = r_err;

  assign axi.m_axi_awaddr  = r_addr;
  assign axi.m_axi_awprot  = 3'b000;
  assign axi.m_axi_awvalid = r_awvalid;
  assign axi.m_axi_wdata   = r_wdata;
  assign axi.m_axi_wstrb   = 4'hF;
  assign axi.m_axi_wvalid  = r_wvalid;
  assign axi.m_axi_bready  = r_bready;
  assign axi.m_axi_araddr  = r_addr;
  assign axi.m_axi_arprot  = 3'b000;
  assign axi.m_axi_arvalid = r_arvalid;
  assign axi.m_axi_rready  = r_rready;

endmodule

// File: tb/tb_vga_reg_access_arbiter.sv
// Testbench for vga_reg_access_arbiter: AXI4-Lite slave model plus scoreboard.
// Ports: none; drives clock/reset and both interfaces.
module tb_vga_reg_access_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vga_req_if  #(.AW(AW), .DW(DW)) rq ();
  vga_axil_if #(.AW(AW), .DW(DW)) ax ();

  vga_reg_access_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req  (rq),
    .axi  (ax)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI4-Lite slave model: four registers, programmable AW/W stalls,
  // programmable BRESP, optional R blocking.
  logic [31:0] smem [4];
  int          aw_lat = 0;
  int          w_lat  = 0;
  int          aw_cnt;
  int          w_cnt;
  bit          aw_got;
  bit          w_got;
  logic [3:0]  aw_a;
  logic [31:0] w_d;
  logic [1:0]  bresp_cfg = 2'b00;
  bit          r_block   = 1'b0;
  logic        aw_hs, w_hs, ar_hs;

  assign aw_hs = ax.m_axi_awvalid & ax.m_axi_awready;
  assign w_hs  = ax.m_axi_wvalid  & ax.m_axi_wready;
  assign ar_hs = ax.m_axi_arvalid & ax.m_axi_arready;

  always_comb begin
    ax.m_axi_awready = !aw_got && (aw_cnt >= aw_lat);
    ax.m_axi_wready  = !w_got  && (w_cnt  >= w_lat);
    ax.m_axi_arready = 1'b1;
  end

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) smem[i] <= '0;
      aw_cnt <= 0;
      w_cnt  <= 0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      aw_a   <= '0;
      w_d    <= '0;
      ax.m_axi_bvalid <= 1'b0;
      ax.m_axi_bresp  <= 2'b00;
      ax.m_axi_rvalid <= 1'b0;
      ax.m_axi_rdata  <= '0;
      ax.m_axi_rresp  <= 2'b00;
    end else begin
      aw_cnt <= (ax.m_axi_awvalid && !aw_hs) ? aw_cnt + 1 : 0;
      w_cnt  <= (ax.m_axi_wvalid  && !w_hs)  ? w_cnt + 1  : 0;
      if (aw_hs) begin
        aw_got <= 1'b1;
        aw_a   <= ax.m_axi_awaddr;
      end
      if (w_hs) begin
        w_got <= 1'b1;
        w_d   <= ax.m_axi_wdata;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs) && !ax.m_axi_bvalid) begin
        smem[aw_hs ? ax.m_axi_awaddr[3:2] : aw_a[3:2]] <=
          w_hs ? ax.m_axi_wdata : w_d;
        ax.m_axi_bvalid <= 1'b1;
        ax.m_axi_bresp  <= bresp_cfg;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (ax.m_axi_bvalid && ax.m_axi_bready) ax.m_axi_bvalid <= 1'b0;
      if (ar_hs && !r_block) begin
        ax.m_axi_rvalid <= 1'b1;
        ax.m_axi_rdata  <= smem[ax.m_axi_araddr[3:2]];
        ax.m_axi_rresp  <= 2'b00;
      end
      if (ax.m_axi_rvalid && ax.m_axi_rready) ax.m_axi_rvalid <= 1'b0;
    end
  end

  // Scoreboard: expectation pushed at grant, popped at done.
  typedef struct {
    int          r;
    logic [31:0] data;
    logic [1:0]  resp;
    int          gcyc;
  } exp_t;

  exp_t        sb [$];
  int          gnt_log [$];
  logic [31:0] mmem [4];
  logic [31:0] m_last;
  int          cyc = 0;
  bit          lat_chk = 1'b1;
  int          done_cnt = 0;
  int          done0_cnt = 0;
  int          aw_cyc = 0;
  int          w_cyc = 0;
  int          b_cnt = 0;
  bit          aw_watch = 1'b0;
  logic [3:0]  aw_exp_addr = '0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t       e;
    logic [3:0] a;
    if (reset) begin
      sb.delete();
      for (int i = 0; i < 4; i++) mmem[i] = '0;
      m_last = '0;
    end else begin
      if (rq.done != 2'b00) begin
        done_cnt++;
        if (rq.done[0]) done0_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", {62'd0, rq.done}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_who", {62'd0, rq.done}, (e.r == 1) ? 64'd2 : 64'd1);
          chk("rd_data", {32'd0, rq.rd_data}, {32'd0, e.data});
          chk("rd_resp", {62'd0, rq.rd_resp}, {62'd0, e.resp});
          if (lat_chk) chk("latency", 64'(cyc - e.gcyc), 64'd3);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (rq.req_ready[i]) begin
          a = rq.req_addr[i*AW +: AW];
          e.r = i;
          if (rq.req_we[i]) begin
            mmem[a[3:2]] = rq.req_wdata[i*DW +: DW];
            e.resp = bresp_cfg;
          end else begin
            m_last = mmem[a[3:2]];
            e.resp = 2'b00;
          end
          e.data = m_last;
          e.gcyc = cyc;
          sb.push_back(e);
          gnt_log.push_back(i);
        end
      end
      if (ax.m_axi_awvalid) begin
        aw_cyc++;
        if (aw_watch)
          chk("awaddr_stable", {60'd0, ax.m_axi_awaddr}, {60'd0, aw_exp_addr});
      end
      if (ax.m_axi_wvalid) w_cyc++;
      if (ax.m_axi_bvalid && ax.m_axi_bready) b_cnt++;
    end
  end

  task automatic access(input int r, input bit we, input logic [3:0] a,
                        input logic [31:0] d);
    int n = 0;
    rq.req_valid[r]          = 1'b1;
    rq.req_we[r]             = we;
    rq.req_addr[r*AW +: AW]  = a;
    rq.req_wdata[r*DW +: DW] = d;
    @(negedge clock);
    while (!rq.req_ready[r] && n < 50) begin
      n++;
      @(negedge clock);
    end
    chk("grant_seen", {63'd0, rq.req_ready[r]}, 64'd1);
    @(posedge clock); #1;
    rq.req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int g;
    int n;
    rq.req_valid = 2'b11;
    rq.req_we    = 2'b00;
    rq.req_addr  = '0;
    rq.req_wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", {62'd0, rq.req_ready}, 64'd0);
    chk("rst_done", {62'd0, rq.done}, 64'd0);
    chk("rst_err", {63'd0, rq.err}, 64'd0);
    chk("rst_rd_data", {32'd0, rq.rd_data}, 64'd0);
    chk("rst_rd_resp", {62'd0, rq.rd_resp}, 64'd0);
    chk("rst_awvalid", {63'd0, ax.m_axi_awvalid}, 64'd0);
    chk("rst_wvalid", {63'd0, ax.m_axi_wvalid}, 64'd0);
    chk("rst_arvalid", {63'd0, ax.m_axi_arvalid}, 64'd0);
    chk("rst_bready", {63'd0, ax.m_axi_bready}, 64'd0);
    chk("rst_rready", {63'd0, ax.m_axi_rready}, 64'd0);
    chk("wstrb", {60'd0, ax.m_axi_wstrb}, 64'hF);
    chk("prot", {58'd0, ax.m_axi_awprot, ax.m_axi_arprot}, 64'd0);
    @(posedge clock); #1;
    rq.req_valid = 2'b00;
    reset = 1'b0;
    @(posedge clock); #1;

    // Both requesters held valid: strict alternation starting with 0.
    gnt_log.delete();
    rq.req_we    = 2'b01;
    rq.req_addr  = {4'h8, 4'h8};
    rq.req_wdata = {32'h0, 32'hA0};
    rq.req_valid = 2'b11;
    g = 0;
    n = 0;
    while (g < 6 && n < 200) begin
      @(negedge clock);
      n++;
      if (rq.req_ready != 2'b00) g++;
    end
    @(posedge clock); #1;
    rq.req_valid = 2'b00;
    chk("fair_count", 64'(gnt_log.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < gnt_log.size())
        chk("fair_order", 64'(gnt_log[i]), 64'(i % 2));
    drain();

    // Requester 0 writes then reads back all four registers.
    base = done0_cnt;
    for (int i = 0; i < 4; i++) access(0, 1'b1, 4'(i * 4), 32'(i + 1));
    for (int i = 0; i < 4; i++) access(0, 1'b0, 4'(i * 4), 32'h0);
    drain();
    chk("done0_count", 64'(done0_cnt - base), 64'd8);
    chk("rd_last", {32'd0, rq.rd_data}, 64'd4);
    chk("err_clean", {63'd0, rq.err}, 64'd0);

    // AW stalled 3 cycles, W stalled 1 cycle.
    lat_chk     = 1'b0;
    aw_lat      = 3;
    w_lat       = 1;
    aw_cyc      = 0;
    w_cyc       = 0;
    b_cnt       = 0;
    base        = done_cnt;
    aw_exp_addr = 4'h4;
    aw_watch    = 1'b1;
    access(0, 1'b1, 4'h4, 32'h55);
    drain();
    aw_watch = 1'b0;
    chk("aw_cycles", 64'(aw_cyc), 64'd4);
    chk("w_cycles", 64'(w_cyc), 64'd2);
    chk("b_count", 64'(b_cnt), 64'd1);
    chk("stall_done", 64'(done_cnt - base), 64'd1);
    aw_lat  = 0;
    w_lat   = 0;
    lat_chk = 1'b1;

    // SLVERR on a requester-1 write; err is sticky.
    bresp_cfg = 2'b10;
    access(1, 1'b1, 4'hC, 32'hDEAD);
    drain();
    bresp_cfg = 2'b00;
    chk("err_set", {63'd0, rq.err}, 64'd1);
    chk("err_resp", {62'd0, rq.rd_resp}, 64'd2);
    access(0, 1'b0, 4'h0, 32'h0);
    access(1, 1'b1, 4'h8, 32'h7);
    drain();
    chk("err_sticky", {63'd0, rq.err}, 64'd1);

    // Reset while waiting for R.
    r_block = 1'b1;
    access(0, 1'b0, 4'h4, 32'h0);
    n = 0;
    while (!ax.m_axi_rready && n < 20) begin
      n++;
      @(negedge clock);
    end
    chk("in_rd_data", {63'd0, ax.m_axi_rready}, 64'd1);
    @(posedge clock); #1;
    base  = done_cnt;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("mid_rst_arvalid", {63'd0, ax.m_axi_arvalid}, 64'd0);
    chk("mid_rst_rready", {63'd0, ax.m_axi_rready}, 64'd0);
    chk("mid_rst_done", {62'd0, rq.done}, 64'd0);
    @(posedge clock); #1;
    reset   = 1'b0;
    r_block = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("no_done_after_rst", {62'd0, rq.done}, 64'd0);
    end
    chk("rst_done_count", 64'(done_cnt - base), 64'd0);
    chk("err_cleared", {63'd0, rq.err}, 64'd0);
    @(posedge clock); #1;
    access(0, 1'b0, 4'h4, 32'h0);
    drain();
    chk("post_rst_read", {32'd0, rq.rd_data}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
